// File: rtl/bfp_block_accumulator.sv
// Block-floating-point block accumulator.
// Accepts one exponent-aligned operand pair per beat, adds the pair as signed
// integers, accumulates BLOCK_LEN pairs (re-aligning when the block exponent
// grows) and emits one sign-magnitude result per block.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   operand pair handshake
//   in_op1, in_op2      {sign, exp[E-1:0], mantissa[M-1:0]}, equal exponents
//   out_valid/out_ready result handshake
//   out_sign, out_exp   result sign and signed block exponent
//   out_mag             unnormalized result magnitude, input-mantissa LSB weight
module bfp_block_accumulator #(
    parameter int unsigned E         = 8,
    parameter int unsigned M         = 23,
    parameter int unsigned BLOCK_LEN = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [E+M:0]                    in_op1,
    input  logic [E+M:0]                    in_op2,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            out_sign,
    output logic [E-1:0]                    out_exp,
    output logic [M+$clog2(BLOCK_LEN):0]    out_mag
);

    localparam int unsigned CNT_W = $clog2(BLOCK_LEN + 1);
    localparam int unsigned ACC_W = M + 2 + $clog2(BLOCK_LEN);
    localparam int unsigned EXT_W = ACC_W - M - 2;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          count;
    logic                      accept, transfer;

    logic                      a_valid, a_last, a_first;
    logic signed [M+1:0]       pair_sum;
    logic signed [E-1:0]       pair_exp;

    logic signed [ACC_W-1:0]   acc, acc_d, acc_abs, sum_ext;
    logic signed [E-1:0]       acc_exp, acc_exp_d;

    logic [M+1:0]              mag1, mag2;
    logic signed [M+1:0]       sval1, sval2;
    logic signed [E:0]         exp_diff;
    logic [E:0]                shamt;
    logic                      grow;

    // op2's exponent duplicates op1's; the abs MSB is always zero by headroom.
    logic unused_bits;
    assign unused_bits = ^{in_op2[E+M-1:M], acc_abs[ACC_W-1]};

    // Arithmetic right shift that saturates to pure sign fill for large distances.
    function automatic logic signed [ACC_W-1:0] sar(input logic signed [ACC_W-1:0] v,
                                                    input logic [E:0] d);
        if (32'(d) >= ACC_W) sar = {ACC_W{v[ACC_W-1]}};
        else                 sar = v >>> d;
    endfunction

    // Handshake qualifiers; in_ready is forced low while reset is asserted.
    assign in_ready = rst_n && (state_q != DONE) && (count < CNT_W'(BLOCK_LEN));
    assign accept   = in_valid && in_ready;
    assign transfer = out_valid && out_ready;

    // Sign-magnitude to two's complement for each operand.
    assign mag1  = {2'b00, in_op1[M-1:0]};
    assign mag2  = {2'b00, in_op2[M-1:0]};
    assign sval1 = in_op1[E+M] ? -$signed(mag1) : $signed(mag1);
    assign sval2 = in_op2[E+M] ? -$signed(mag2) : $signed(mag2);

    // Stage A: register the pair sum and its block position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid  <= 1'b0;
            a_last   <= 1'b0;
            a_first  <= 1'b0;
            pair_sum <= '0;
            pair_exp <= '0;
        end else begin
            a_valid <= accept;
            if (accept) begin
                pair_sum <= sval1 + sval2;
                pair_exp <= in_op1[E+M-1:M];
                a_first  <= (count == '0);
                a_last   <= (count == CNT_W'(BLOCK_LEN - 1));
            end
        end
    end

    // Exponent difference in E+1 bits so it never wraps.
    assign exp_diff = {pair_exp[E-1], pair_exp} - {acc_exp[E-1], acc_exp};
    assign grow     = !exp_diff[E] && (exp_diff != '0);
    assign shamt    = grow ? exp_diff : -exp_diff;
    assign sum_ext  = {{EXT_W{pair_sum[M+1]}}, pair_sum};

    // Stage B: accumulate, aligning the smaller-exponent operand down.
    always_comb begin
        acc_d     = acc;
        acc_exp_d = acc_exp;
        if (a_valid) begin
            if (a_first) begin
                acc_d     = sum_ext;
                acc_exp_d = pair_exp;
            end else if (grow) begin
                acc_d     = sar(acc, shamt) + sum_ext;
                acc_exp_d = pair_exp;
            end else begin
                acc_d     = acc + sar(sum_ext, shamt);
            end
        end
    end

    assign acc_abs = acc_d[ACC_W-1] ? -acc_d : acc_d;

    // FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept)             state_d = ACCUM;
            ACCUM:   if (a_valid && a_last)  state_d = DONE;
            DONE:    if (transfer)           state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    // State, counter, accumulator and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count     <= '0;
            acc       <= '0;
            acc_exp   <= '0;
            out_valid <= 1'b0;
            out_sign  <= 1'b0;
            out_exp   <= '0;
            out_mag   <= '0;
        end else begin
            state_q <= state_d;
            acc     <= acc_d;
            acc_exp <= acc_exp_d;
            if (transfer)    count <= '0;
            else if (accept) count <= count + CNT_W'(1);
            if (state_q == ACCUM && state_d == DONE) begin
                out_valid <= 1'b1;
                out_sign  <= acc_d[ACC_W-1];
                out_exp   <= acc_exp_d;
                out_mag   <= acc_abs[ACC_W-2:0];
            end else if (transfer) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bfp_block_accumulator.sv
// Self-checking bench for bfp_block_accumulator: directed blocks, a behavioural
// block model with a per-cycle output compare, and literal result checks.
module tb_bfp_block_accumulator;

    localparam int E         = 8;
    localparam int M         = 23;
    localparam int BLOCK_LEN = 4;
    localparam int MAG_W     = M + 1 + $clog2(BLOCK_LEN);

    typedef struct {
        logic   sign;
        int     e;
        longint mag;
    } res_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [E+M:0]     in_op1 = '0;
    logic [E+M:0]     in_op2 = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             out_sign;
    logic [E-1:0]     out_exp;
    logic [MAG_W-1:0] out_mag;

    int checks = 0;
    int errors = 0;
    int n_results = 0;
    logic   last_sign;
    int     last_exp;
    longint last_mag;

    longint blk_sum[$];
    int     blk_exp[$];
    res_t   expq[$];

    bfp_block_accumulator #(.E(E), .M(M), .BLOCK_LEN(BLOCK_LEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op1(in_op1), .in_op2(in_op2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_exp(out_exp), .out_mag(out_mag)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input longint got, input longint want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d at %0t", nm, got, want, $time);
        end
    endtask

    function automatic logic [E+M:0] op(input bit s, input int e, input int m);
        return {s, E'(e), M'(m)};
    endfunction

    function automatic longint sra(input longint v, input int d);
        int dd = (d > 63) ? 63 : d;
        return v >>> dd;
    endfunction

    // Reference: fold the block's pair sums left to right at the growing exponent.
    function automatic res_t model_block();
        res_t   r;
        longint acc = blk_sum[0];
        int     ae  = blk_exp[0];
        for (int i = 1; i < blk_sum.size(); i++) begin
            if (blk_exp[i] > ae) begin
                acc = sra(acc, blk_exp[i] - ae) + blk_sum[i];
                ae  = blk_exp[i];
            end else begin
                acc = acc + sra(blk_sum[i], ae - blk_exp[i]);
            end
        end
        r.sign = (acc < 0);
        r.mag  = (acc < 0) ? -acc : acc;
        r.e    = ae;
        return r;
    endfunction

    task automatic model_accept(input logic [E+M:0] a, input logic [E+M:0] b);
        longint va = longint'(a[M-1:0]);
        longint vb = longint'(b[M-1:0]);
        if (a[E+M]) va = -va;
        if (b[E+M]) vb = -vb;
        blk_sum.push_back(va + vb);
        blk_exp.push_back(int'($signed(a[E+M-1:M])));
        if (blk_sum.size() == BLOCK_LEN) begin
            expq.push_back(model_block());
            blk_sum.delete();
            blk_exp.delete();
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input logic [E+M:0] a, input logic [E+M:0] b);
        int n = 0;
        in_op1   = a;
        in_op2   = b;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            sync();
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            model_accept(a, b);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_result(input int n0);
        int n = 0;
        while (n_results == n0 && n < 100) begin
            sync();
            n++;
        end
        if (n_results == n0) check("result_timeout", 0, 1);
    endtask

    task automatic check_last(input string nm, input logic s, input int e, input longint m);
        check({nm, "_sign"}, longint'(last_sign), longint'(s));
        check({nm, "_exp"}, longint'(last_exp), longint'(e));
        check({nm, "_mag"}, last_mag, m);
    endtask

    // Compare process: every valid output cycle against the model's front entry.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result got_mag=%0d want=none", out_mag);
            end else begin
                check("cmp_sign", longint'(out_sign), longint'(expq[0].sign));
                check("cmp_exp", longint'($signed(out_exp)), longint'(expq[0].e));
                check("cmp_mag", longint'(out_mag), expq[0].mag);
                check("cmp_busy_in_ready", longint'(in_ready), 0);
                if (out_ready) begin
                    last_sign = out_sign;
                    last_exp  = int'($signed(out_exp));
                    last_mag  = longint'(out_mag);
                    void'(expq.pop_front());
                    n_results++;
                end
            end
        end
    end

    initial begin
        int n0;
        logic [MAG_W-1:0] hold_mag;
        logic [E-1:0]     hold_exp;
        logic             hold_sign;
        int               wn;

        // Reset state.
        #2;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_in_ready", longint'(in_ready), 0);
        check("rst_out_mag", longint'(out_mag), 0);
        #10 rst_n = 1'b1;
        sync();

        // Equal exponents and output latency.
        n0 = n_results;
        for (int i = 0; i < 4; i++) send(op(0, 5, 100), op(0, 5, 50));
        @(negedge clk);
        check("latency_early", longint'(out_valid), 0);
        @(negedge clk);
        check("latency_on", longint'(out_valid), 1);
        sync();
        wait_result(n0);
        check_last("equal", 1'b0, 5, 600);

        // Exponent growth with input bubbles.
        n0 = n_results;
        send(op(0, 3, 64), op(0, 3, 0));
        sync(); sync();
        send(op(0, 5, 16), op(0, 5, 0));
        sync();
        send(op(0, 5, 0), op(0, 5, 0));
        sync(); sync(); sync();
        send(op(0, 5, 0), op(0, 5, 0));
        wait_result(n0);
        check_last("growth", 1'b0, 5, 32);

        // Negative pairs cancel, then the same with signs swapped.
        n0 = n_results;
        for (int i = 0; i < 2; i++) send(op(1, 2, 40), op(0, 2, 10));
        for (int i = 0; i < 2; i++) send(op(0, 2, 30), op(0, 2, 30));
        wait_result(n0);
        check_last("cancel_pos", 1'b0, 2, 60);
        n0 = n_results;
        for (int i = 0; i < 2; i++) send(op(0, 2, 40), op(1, 2, 10));
        for (int i = 0; i < 2; i++) send(op(1, 2, 30), op(1, 2, 30));
        wait_result(n0);
        check_last("cancel_neg", 1'b1, 2, 60);

        // Saturating shift across a huge exponent gap.
        n0 = n_results;
        send(op(0, -100, 7), op(0, -100, 0));
        send(op(0, 100, 1), op(0, 100, 0));
        send(op(0, 100, 0), op(0, 100, 0));
        send(op(0, 100, 0), op(0, 100, 0));
        wait_result(n0);
        check_last("saturate", 1'b0, 100, 1);

        // Negative values shifted both ways round toward minus infinity.
        n0 = n_results;
        send(op(1, 0, 5), op(0, 0, 0));
        send(op(0, 1, 0), op(0, 1, 0));
        send(op(1, 0, 3), op(0, 0, 0));
        send(op(0, 1, 0), op(0, 1, 0));
        wait_result(n0);
        check_last("neg_shift", 1'b1, 1, 5);

        // Backpressure: result held, input blocked, release on out_ready.
        out_ready = 1'b0;
        n0 = n_results;
        for (int i = 0; i < 4; i++) send(op(1, -3, 9), op(1, -3, 1));
        wn = 0;
        while (!out_valid && wn < 20) begin
            @(negedge clk);
            wn++;
        end
        check("bp_valid_seen", longint'(out_valid), 1);
        hold_mag  = out_mag;
        hold_exp  = out_exp;
        hold_sign = out_sign;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", longint'(out_valid), 1);
            check("bp_hold_mag", longint'(out_mag), longint'(hold_mag));
            check("bp_hold_exp", longint'(out_exp), longint'(hold_exp));
            check("bp_hold_sign", longint'(out_sign), longint'(hold_sign));
            check("bp_in_ready", longint'(in_ready), 0);
        end
        sync();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_in_ready_after", longint'(in_ready), 1);
        check("bp_valid_after", longint'(out_valid), 0);
        check("bp_result_count", longint'(n_results), longint'(n0 + 1));
        check_last("backpressure", 1'b1, -3, 40);
        sync();

        // Reset mid-block discards the partial sum.
        n0 = n_results;
        send(op(0, 0, 4), op(0, 0, 6));
        send(op(0, 0, 4), op(0, 0, 6));
        #3 rst_n = 1'b0;
        blk_sum.delete();
        blk_exp.delete();
        #1;
        check("mid_rst_valid", longint'(out_valid), 0);
        check("mid_rst_sign", longint'(out_sign), 0);
        check("mid_rst_exp", longint'(out_exp), 0);
        check("mid_rst_mag", longint'(out_mag), 0);
        check("mid_rst_in_ready", longint'(in_ready), 0);
        @(posedge clk);
        #1;
        check("mid_rst_in_ready_edge", longint'(in_ready), 0);
        #2 rst_n = 1'b1;
        sync();
        for (int i = 0; i < 4; i++) send(op(0, 0, 1), op(0, 0, 0));
        wait_result(n0);
        check_last("after_reset", 1'b0, 0, 4);

        repeat (4) sync();
        check("leftover_results", longint'(expq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bfp_block_accumulator.md
Name: bfp_block_accumulator

Overview:
- Sits directly downstream of the two-operand block-floating-point normalization stage.
- Each beat consumes one aligned operand pair: {sign, shared exponent, shifted mantissa} in the 1+E+M format, with both exponents equal.
- Adds the pair as signed integers and accumulates BLOCK_LEN pairs into a wide accumulator, re-aligning whenever the block exponent grows.
- Emits one sign-magnitude block result per block over a valid/ready handshake.

Parameters:
- E, 8, exponent field width (signed two's complement).
- M, 23, mantissa field width.
- BLOCK_LEN, 4, pairs accumulated per result (≥2).
- CNT_W, $clog2(BLOCK_LEN+1), pair counter width (derived, localparam).
- ACC_W, M+2+$clog2(BLOCK_LEN), signed accumulator width (derived, localparam).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts a pair this cycle.
- in_op1  in  1+E+M  {sign, exp, mantissa} from normalization out1.
- in_op2  in  1+E+M  {sign, exp, mantissa} from normalization out2.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_sign  out  1  result sign (1 = negative).
- out_exp  out  E  signed block exponent of result.
- out_mag  out  ACC_W-1  result magnitude, unnormalized, same LSB weight as input mantissa.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, count=0, all stage valids 0.
  - acc=0, acc_exp=0.
  - out_valid=0, out_sign=0, out_exp=0, out_mag=0.
  - in_ready=0 while rst_n=0.
- Handshake:
  - A pair is accepted when in_valid && in_ready.
  - in_ready = (state != DONE) && (count < BLOCK_LEN).
  - A result transfers when out_valid && out_ready.
- Stage A (registered, one cycle after accept):
  - pair_sum = signed(op1) + signed(op2), width M+2, where signed(x) = sign ? −mantissa : mantissa.
  - Exponent taken from in_op1; in_op2's exponent is ignored (equal by contract).
  - Registers pair_sum, pair_exp, a_valid, a_last. a_last is set on accept number BLOCK_LEN.
- Stage B (accumulate, on a_valid):
  - First pair of a block: acc = sign-extended pair_sum, acc_exp = pair_exp.
  - Else if pair_exp > acc_exp (signed compare): acc = (acc >>> d) + pair_sum, acc_exp = pair_exp, where d = pair_exp − acc_exp.
  - Else: acc = acc + (pair_sum >>> d), where d = acc_exp − pair_exp.
  - Shifts are arithmetic (truncate toward −inf). d ≥ ACC_W saturates the shifted operand to all sign bits (0 or −1).
  - Exponent difference is computed in E+1 bits; no wrap.
- FSM:
  - IDLE → ACCUM on first accept.
  - ACCUM → DONE when stage B processes the a_last entry.
  - DONE → IDLE on output transfer; count clears on that cycle.
- Output (registered on entry to DONE):
  - out_sign = acc[ACC_W-1]; out_mag = |acc| (headroom guarantees no overflow); out_exp = acc_exp.
  - A zero result gives out_sign=0, out_mag=0.
- Latency: out_valid rises 2 cycles after the BLOCK_LEN-th accept.
- Outputs are held stable while out_valid && !out_ready.
- No new block starts until the result transfers. The next accept is possible the cycle after transfer.
- Input bubbles (in_valid=0) anywhere mid-block are legal and do not change the result.
- Reset mid-block discards the partial accumulation; the next accepted pair after release starts a fresh block.

Test Plan:
- Equal exponents: 4 pairs, each op1={0,5,100}, op2={0,5,50} → out_valid exactly 2 cycles after 4th accept; out_sign=0, out_exp=5, out_mag=600.
- Exponent growth: pairs sums 64@exp3, 16@exp5, 0@exp5, 0@exp5 → out_exp=5, out_mag=32.
- Negative/cancel: pairs {1,2,40}+{0,2,10} ×2 and {0,2,30}+{0,2,30} ×2 → out_sign=0, out_mag=60. Swap signs → out_sign=1, out_mag=60.
- Saturating shift: pair1 sum 7@exp −100, pair2 sum 1@exp 100, rest 0@exp 100 → out_exp=100, out_mag=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → outputs stable, in_ready=0. Raise out_ready → transfer; in_ready=1 next cycle.
- Reset mid-block: accept 2 pairs (sum 10 each), pulse rst_n low asynchronously between clock edges, then feed 4 pairs of sum 1@exp 0 → out_mag=4, out_exp=0; all outputs 0 during reset.
